// File: rtl/rs_generic.sv
// rs_generic: parametrised reservation station between rename/dispatch and
// one functional unit. Oldest-first select keyed on ROB age, same-cycle
// dispatch wakeup, and selective squash of entries younger than a branch.
module rs_generic #(
   parameter int DEPTH     = 8,
   parameter int NUM_CDB   = 2,
   parameter int PREG_W    = 7,
   parameter int ROB_W     = 4,
   parameter int PAYLOAD_W = 80
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        dispatch_valid,
   output logic                        dispatch_ready,
   input  logic [PREG_W-1:0]           dispatch_prs1,
   input  logic [PREG_W-1:0]           dispatch_prs2,
   input  logic                        dispatch_prs1_ready,
   input  logic                        dispatch_prs2_ready,
   input  logic [ROB_W-1:0]            dispatch_rob_tag,
   input  logic [PAYLOAD_W-1:0]        dispatch_payload,
   input  logic [NUM_CDB-1:0]          cdb_valid,
   input  logic [NUM_CDB*PREG_W-1:0]   cdb_prd,
   output logic                        issue_valid,
   input  logic                        issue_ready,
   output logic [PREG_W-1:0]           issue_prs1,
   output logic [PREG_W-1:0]           issue_prs2,
   output logic [ROB_W-1:0]            issue_rob_tag,
   output logic [PAYLOAD_W-1:0]        issue_payload,
   input  logic [ROB_W-1:0]            rob_head,
   input  logic                        flush_valid,
   input  logic                        flush_all,
   input  logic [ROB_W-1:0]            flush_rob_tag,
   output logic [$clog2(DEPTH):0]      free_count,
   output logic                        empty
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = IDX_W + 1;

   // Control state (reset) and per-entry data (write-enabled only).
   logic [DEPTH-1:0]     valid_q, valid_d;
   logic [DEPTH-1:0]     rdy1_q, rdy1_d;
   logic [DEPTH-1:0]     rdy2_q, rdy2_d;
   logic [PREG_W-1:0]    prs1_q [DEPTH];
   logic [PREG_W-1:0]    prs2_q [DEPTH];
   logic [ROB_W-1:0]     rob_q  [DEPTH];
   logic [PAYLOAD_W-1:0] pay_q  [DEPTH];

   logic [DEPTH-1:0]     hit1, hit2;
   logic                 disp_hit1, disp_hit2;
   logic [CNT_W-1:0]     free_cnt;
   logic [IDX_W-1:0]     alloc_idx;
   logic [IDX_W-1:0]     sel_idx;
   logic                 sel_found;
   logic [ROB_W-1:0]     sel_age;
   logic                 disp_fire, issue_fire;

   // Age relative to the ROB head; modular subtraction handles wrap.
   function automatic logic [ROB_W-1:0] age_of(input logic [ROB_W-1:0] tag,
                                               input logic [ROB_W-1:0] head);
      return tag - head;
   endfunction

   // CDB tag match for every stored source and for the incoming dispatch.
   always_comb begin
      hit1      = '0;
      hit2      = '0;
      disp_hit1 = 1'b0;
      disp_hit2 = 1'b0;
      for (int c = 0; c < NUM_CDB; c++) begin
         if (cdb_valid[c]) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (cdb_prd[c*PREG_W +: PREG_W] == prs1_q[i]) hit1[i] = 1'b1;
               if (cdb_prd[c*PREG_W +: PREG_W] == prs2_q[i]) hit2[i] = 1'b1;
            end
            if (cdb_prd[c*PREG_W +: PREG_W] == dispatch_prs1) disp_hit1 = 1'b1;
            if (cdb_prd[c*PREG_W +: PREG_W] == dispatch_prs2) disp_hit2 = 1'b1;
         end
      end
   end

   // Count invalid entries; slots freed this cycle only show up next cycle.
   always_comb begin
      free_cnt = '0;
      for (int i = 0; i < DEPTH; i++)
         if (!valid_q[i]) free_cnt = free_cnt + CNT_W'(1);
   end

   assign free_count     = free_cnt;
   assign empty          = (free_cnt == CNT_W'(DEPTH));
   assign dispatch_ready = (free_cnt != '0) & ~flush_valid;

   // Lowest-index invalid entry receives the next dispatch.
   always_comb begin
      alloc_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--)
         if (!valid_q[i]) alloc_idx = IDX_W'(i);
   end

   // Oldest eligible entry, from registered state only.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      sel_age   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && rdy1_q[i] && rdy2_q[i] &&
             (!sel_found || age_of(rob_q[i], rob_head) < sel_age)) begin
            sel_found = 1'b1;
            sel_idx   = IDX_W'(i);
            sel_age   = age_of(rob_q[i], rob_head);
         end
      end
   end

   assign issue_valid   = sel_found & ~flush_valid;
   assign issue_prs1    = sel_found ? prs1_q[sel_idx] : '0;
   assign issue_prs2    = sel_found ? prs2_q[sel_idx] : '0;
   assign issue_rob_tag = sel_found ? rob_q[sel_idx]  : '0;
   assign issue_payload = sel_found ? pay_q[sel_idx]  : '0;

   assign disp_fire  = dispatch_valid & dispatch_ready;
   assign issue_fire = issue_valid & issue_ready;

   // Next-state: flush dominates; otherwise issue frees and dispatch fills.
   // Wakeups apply every cycle, including the flush cycle.
   always_comb begin
      valid_d = valid_q;
      rdy1_d  = rdy1_q | hit1;
      rdy2_d  = rdy2_q | hit2;
      if (flush_valid) begin
         for (int i = 0; i < DEPTH; i++)
            if (flush_all ||
                age_of(rob_q[i], rob_head) > age_of(flush_rob_tag, rob_head))
               valid_d[i] = 1'b0;
      end else begin
         if (issue_fire) valid_d[sel_idx] = 1'b0;
         if (disp_fire) begin
            valid_d[alloc_idx] = 1'b1;
            rdy1_d[alloc_idx]  = dispatch_prs1_ready | (dispatch_prs1 == '0) | disp_hit1;
            rdy2_d[alloc_idx]  = dispatch_prs2_ready | (dispatch_prs2 == '0) | disp_hit2;
         end
      end
   end

   // Valid and ready bits, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         rdy1_q  <= '0;
         rdy2_q  <= '0;
      end else begin
         valid_q <= valid_d;
         rdy1_q  <= rdy1_d;
         rdy2_q  <= rdy2_d;
      end
   end

   // Entry data is only meaningful while valid, so it needs no reset.
   always_ff @(posedge clk) begin
      if (disp_fire) begin
         prs1_q[alloc_idx] <= dispatch_prs1;
         prs2_q[alloc_idx] <= dispatch_prs2;
         rob_q[alloc_idx]  <= dispatch_rob_tag;
         pay_q[alloc_idx]  <= dispatch_payload;
      end
   end

   a_free_bound: assert property (@(posedge clk) disable iff (!rst_n)
                                  free_count <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_rs_generic.sv
// tb_rs_generic: randomized and directed stimulus against a queue-based
// reference model of the reservation station.
module tb_rs_generic;
   localparam int DEPTH = 8, NUM_CDB = 2, PREG_W = 7, ROB_W = 4, PAYLOAD_W = 80;

   logic clk = 1'b0, rst_n = 1'b0;
   logic dispatch_valid, dispatch_ready;
   logic [PREG_W-1:0] dispatch_prs1, dispatch_prs2;
   logic dispatch_prs1_ready, dispatch_prs2_ready;
   logic [ROB_W-1:0] dispatch_rob_tag;
   logic [PAYLOAD_W-1:0] dispatch_payload;
   logic [NUM_CDB-1:0] cdb_valid;
   logic [NUM_CDB*PREG_W-1:0] cdb_prd;
   logic issue_valid, issue_ready;
   logic [PREG_W-1:0] issue_prs1, issue_prs2;
   logic [ROB_W-1:0] issue_rob_tag;
   logic [PAYLOAD_W-1:0] issue_payload;
   logic [ROB_W-1:0] rob_head, flush_rob_tag;
   logic flush_valid, flush_all;
   logic [$clog2(DEPTH):0] free_count;
   logic empty;

   rs_generic #(.DEPTH(DEPTH), .NUM_CDB(NUM_CDB), .PREG_W(PREG_W),
                .ROB_W(ROB_W), .PAYLOAD_W(PAYLOAD_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
      .dispatch_prs1(dispatch_prs1), .dispatch_prs2(dispatch_prs2),
      .dispatch_prs1_ready(dispatch_prs1_ready), .dispatch_prs2_ready(dispatch_prs2_ready),
      .dispatch_rob_tag(dispatch_rob_tag), .dispatch_payload(dispatch_payload),
      .cdb_valid(cdb_valid), .cdb_prd(cdb_prd),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_prs1(issue_prs1), .issue_prs2(issue_prs2),
      .issue_rob_tag(issue_rob_tag), .issue_payload(issue_payload),
      .rob_head(rob_head), .flush_valid(flush_valid), .flush_all(flush_all),
      .flush_rob_tag(flush_rob_tag), .free_count(free_count), .empty(empty));

   always #5 clk = ~clk;

   typedef struct {
      int                   sq;
      logic [PREG_W-1:0]    p1, p2;
      bit                   r1, r2;
      logic [ROB_W-1:0]     rob;
      logic [PAYLOAD_W-1:0] pay;
   } ent_t;

   ent_t mq[$];
   int n_chk = 0, n_pass = 0;
   int next_seq = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic bit cdb_hit(input logic [PREG_W-1:0] t, input logic [1:0] cv,
                                  input logic [13:0] cp);
      for (int c = 0; c < NUM_CDB; c++)
         if (cv[c] && cp[c*PREG_W +: PREG_W] == t) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int age(input logic [ROB_W-1:0] t, input logic [ROB_W-1:0] h);
      logic [ROB_W-1:0] d;
      d = t - h;
      return int'(d);
   endfunction

   // One cycle: drive at the falling edge, check, then advance the model.
   task automatic step(input bit dv, input logic [6:0] p1, input logic [6:0] p2,
                       input bit r1, input bit r2, input logic [3:0] rob,
                       input logic [79:0] pay, input int sq,
                       input logic [1:0] cv, input logic [13:0] cp, input bit ir,
                       input logic [3:0] head, input bit fv, input bit fa,
                       input logic [3:0] ft, output bit acc);
      int best;
      bit exp_dr, exp_iv;
      ent_t e;
      dispatch_valid = dv; dispatch_prs1 = p1; dispatch_prs2 = p2;
      dispatch_prs1_ready = r1; dispatch_prs2_ready = r2;
      dispatch_rob_tag = rob; dispatch_payload = pay;
      cdb_valid = cv; cdb_prd = cp; issue_ready = ir; rob_head = head;
      flush_valid = fv; flush_all = fa; flush_rob_tag = ft;
      #1;
      best = -1;
      for (int k = 0; k < mq.size(); k++)
         if (mq[k].r1 && mq[k].r2 &&
             (best < 0 || age(mq[k].rob, head) < age(mq[best].rob, head)))
            best = k;
      exp_dr = (mq.size() < DEPTH) && !fv;
      exp_iv = (best >= 0) && !fv;
      chk("free_count", free_count, DEPTH - mq.size());
      chk("empty", empty, mq.size() == 0);
      chk("dispatch_ready", dispatch_ready, exp_dr);
      chk("issue_valid", issue_valid, exp_iv);
      if (exp_iv) begin
         chk("issue_rob_tag", issue_rob_tag, mq[best].rob);
         chk("issue_prs1", issue_prs1, mq[best].p1);
         chk("issue_prs2", issue_prs2, mq[best].p2);
         chk("issue_payload", issue_payload, mq[best].pay);
      end
      foreach (mq[k]) begin
         if (cdb_hit(mq[k].p1, cv, cp)) mq[k].r1 = 1'b1;
         if (cdb_hit(mq[k].p2, cv, cp)) mq[k].r2 = 1'b1;
      end
      acc = 1'b0;
      if (fv) begin
         for (int k = mq.size() - 1; k >= 0; k--)
            if (fa || age(mq[k].rob, head) > age(ft, head)) mq.delete(k);
      end else begin
         if (exp_iv && ir) mq.delete(best);
         if (dv && exp_dr) begin
            e.sq = sq; e.p1 = p1; e.p2 = p2; e.rob = rob; e.pay = pay;
            e.r1 = r1 || p1 == 0 || cdb_hit(p1, cv, cp);
            e.r2 = r2 || p2 == 0 || cdb_hit(p2, cv, cp);
            mq.push_back(e);
            acc = 1'b1;
         end
      end
      @(negedge clk);
   endtask

   task automatic idle(input bit ir, input logic [3:0] head);
      bit a;
      step(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 14'd0, ir, head, 0, 0, 0, a);
   endtask

   task automatic disp(input logic [6:0] p1, input logic [6:0] p2, input bit r1,
                       input bit r2, input logic [3:0] rob, input logic [3:0] head);
      bit a;
      step(1, p1, p2, r1, r2, rob, {$urandom, $urandom, $urandom}, 0,
           2'b00, 14'd0, 0, head, 0, 0, 0, a);
   endtask

   task automatic rnd_cycle(input int ir_pct);
      int h, k;
      bit dv, fv, fa, a;
      logic [3:0] ft;
      logic [13:0] cp;
      h = next_seq;
      foreach (mq[i]) if (mq[i].sq < h) h = mq[i].sq;
      dv = (next_seq - h <= 14) && ($urandom_range(0, 99) < 70);
      fv = $urandom_range(0, 99) < 4;
      fa = $urandom_range(0, 1) == 1;
      if (mq.size() > 0) begin
         k = $urandom_range(0, mq.size() - 1);
         ft = mq[k].rob;
      end else ft = 4'(h);
      cp = {7'($urandom_range(1, 15)), 7'($urandom_range(1, 15))};
      step(dv, 7'($urandom_range(0, 15)), 7'($urandom_range(0, 15)),
           $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 30,
           4'(next_seq), {$urandom, $urandom, $urandom}, next_seq,
           2'($urandom_range(0, 3)), cp, $urandom_range(0, 99) < ir_pct,
           4'(h), fv, fa, ft, a);
      if (a) next_seq++;
   endtask

   initial begin
      bit a;
      dispatch_valid = 0; dispatch_prs1 = 0; dispatch_prs2 = 0;
      dispatch_prs1_ready = 0; dispatch_prs2_ready = 0; dispatch_rob_tag = 0;
      dispatch_payload = 0; cdb_valid = 0; cdb_prd = 0; issue_ready = 0;
      rob_head = 0; flush_valid = 0; flush_all = 0; flush_rob_tag = 0;
      #3;
      chk("rst_issue_valid", issue_valid, 0);
      chk("rst_issue_rob", issue_rob_tag, 0);
      chk("rst_issue_payload", issue_payload, 0);
      chk("rst_free_count", free_count, DEPTH);
      chk("rst_empty", empty, 1);
      chk("rst_dispatch_ready", dispatch_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      // basic dispatch-issue, then same-cycle CDB capture
      disp(5, 0, 1, 0, 3, 0);
      idle(1, 0);
      idle(0, 0);
      step(1, 9, 0, 0, 0, 4, 80'h1234, 0, 2'b10, {7'd9, 7'd0}, 0, 0, 0, 0, 0, a);
      idle(1, 0);
      idle(0, 0);
      // wrap-around age: head 14, issue order 14, 15, 1
      disp(0, 0, 1, 1, 1, 14);
      disp(0, 0, 1, 1, 15, 14);
      disp(0, 0, 1, 1, 14, 14);
      idle(1, 14); idle(1, 14); idle(1, 14); idle(0, 14);
      // selective flush: head 2, keep 3 and 5, squash 7 and 9
      disp(20, 0, 0, 1, 3, 2);
      disp(20, 0, 0, 1, 5, 2);
      disp(20, 0, 0, 1, 7, 2);
      disp(20, 0, 0, 1, 9, 2);
      step(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 14'd0, 1, 2, 1, 0, 5, a);
      idle(0, 2);
      step(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 14'd0, 0, 2, 1, 1, 0, a);
      // random traffic: a filling phase and a draining phase
      for (int i = 0; i < 300; i++) rnd_cycle(15);
      for (int i = 0; i < 300; i++) rnd_cycle(80);
      for (int i = 0; i < 40; i++) rnd_cycle(5);
      // asynchronous reset between edges
      dispatch_valid = 0; cdb_valid = 0; flush_valid = 0; issue_ready = 0;
      #2 rst_n = 1'b0;
      #1;
      chk("async_issue_valid", issue_valid, 0);
      chk("async_empty", empty, 1);
      chk("async_free_count", free_count, DEPTH);
      mq.delete();
      @(negedge clk);
      rst_n = 1'b1;
      next_seq = 0;
      idle(0, 0);
      for (int i = 0; i < 100; i++) rnd_cycle(50);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
